// File: rtl/io_seq_pkg.sv
// Shared types, encodings and beat helpers for the IO bus sequencer.
package io_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } seq_state_e;

    // Request size encodings as seen on req_size.
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_DWORD = 2'd2;
    localparam logic [1:0] SZ_RSVD  = 2'd3;

    // Bit positions inside control_io = {partial_write, byte_op}.
    localparam int CTRL_BYTE  = 0;
    localparam int CTRL_WRITE = 1;

    // Reserved size behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        logic [1:0] res;
        case (size)
            SZ_BYTE:  res = SZ_BYTE;
            SZ_WORD:  res = SZ_WORD;
            SZ_DWORD: res = SZ_DWORD;
            default:  res = SZ_WORD;
        endcase
        return res;
    endfunction

    // Address of a beat: bytes keep their address, wider accesses are
    // halfword aligned, and the second dword beat sits 2 bytes higher
    // (wrapping at 32 bits).
    function automatic logic [31:0] beat_address(input logic [31:0] addr,
                                                 input logic [1:0]  size,
                                                 input logic        beat);
        logic [31:0] base;
        if (size == SZ_BYTE) begin
            base = addr;
        end else begin
            base = {addr[31:1], 1'b0};
        end
        if (beat) begin
            return base + 32'd2;
        end else begin
            return base;
        end
    endfunction

    // Write data for a beat: low byte for bytes, low/high halfword otherwise.
    function automatic logic [15:0] beat_data(input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic        beat);
        if (size == SZ_BYTE) begin
            return {8'h00, data[7:0]};
        end else if (beat) begin
            return data[31:16];
        end else begin
            return data[15:0];
        end
    endfunction

endpackage

// File: rtl/io_bus_sequencer.sv
// Request sequencer between the CPU load/store path and the memory_io port.
// One request at a time; each 16-bit beat is presented for exactly one cycle,
// loads wait out the fixed IO read latency, dwords are split into two beats.
module io_bus_sequencer
    import io_seq_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic        main_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [31:0] address_io,
    output logic [1:0]  control_io,
    output logic [15:0] data_in_io,
    input  logic [15:0] data_out_io
);

    // WAIT lasts READ_LATENCY-1 cycles; the counter holds the remaining
    // cycles minus one. A latency below 2 skips WAIT entirely.
    localparam int CNT_W         = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam int WAIT_INIT_INT = (READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_INIT_INT);
    localparam bit SKIP_WAIT     = (READ_LATENCY < 2);

    seq_state_e         r_state;
    seq_state_e         w_next_state;
    logic               w_accept;

    logic               r_write;
    logic [1:0]         r_size;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic               r_beat;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic               r_req_ready;
    logic               r_resp_valid;
    logic [31:0]        r_resp_data;
    logic [31:0]        r_address_io;
    logic [1:0]         r_control_io;
    logic [15:0]        r_data_in_io;

    logic               w_more_beats;
    logic               w_src_write;
    logic [1:0]         w_src_size;
    logic [31:0]        w_src_addr;
    logic [31:0]        w_src_data;
    logic               w_drive_beat;
    logic [31:0]        w_drive_addr;
    logic [15:0]        w_drive_data;
    logic [1:0]         w_drive_ctrl;

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign address_io = r_address_io;
    assign control_io = r_control_io;
    assign data_in_io = r_data_in_io;

    // A dword still owes its second beat while the beat flag is clear.
    assign w_more_beats = (r_size == SZ_DWORD) && !r_beat;

    // State register.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and acceptance strobe.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = ST_DRIVE;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (r_write) begin
                    if (w_more_beats) begin
                        w_next_state = ST_DRIVE;
                    end else begin
                        w_next_state = ST_RESP;
                    end
                end else if (SKIP_WAIT) begin
                    w_next_state = ST_CAPTURE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == {CNT_W{1'b0}}) begin
                    w_next_state = ST_CAPTURE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                if (w_more_beats) begin
                    w_next_state = ST_DRIVE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Beat contents for the upcoming DRIVE cycle. On acceptance the request
    // registers are loaded at the same edge, so the raw inputs are used then.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_src_write  = req_write;
            w_src_size   = norm_size(req_size);
            w_src_addr   = req_address;
            w_src_data   = req_data;
            w_drive_beat = 1'b0;
        end else begin
            w_src_write  = r_write;
            w_src_size   = r_size;
            w_src_addr   = r_addr;
            w_src_data   = r_data;
            w_drive_beat = 1'b1;
        end
        w_drive_addr             = beat_address(w_src_addr, w_src_size, w_drive_beat);
        w_drive_data             = beat_data(w_src_data, w_src_size, w_drive_beat);
        w_drive_ctrl             = 2'b00;
        w_drive_ctrl[CTRL_BYTE]  = (w_src_size == SZ_BYTE);
        w_drive_ctrl[CTRL_WRITE] = w_src_write;
    end

    // Request latch and beat flag.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= 32'h0000_0000;
            r_data  <= 32'h0000_0000;
            r_beat  <= 1'b0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_size  <= norm_size(req_size);
            r_addr  <= req_address;
            r_data  <= req_data;
            r_beat  <= 1'b0;
        end else if ((r_state != ST_IDLE) && (w_next_state == ST_DRIVE)) begin
            r_beat  <= 1'b1;
        end else begin
            r_beat  <= r_beat;
        end
    end

    // Read-latency down-counter, loaded on entry to WAIT.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if ((w_next_state == ST_WAIT) && (r_state != ST_WAIT)) begin
            r_wait_cnt <= WAIT_INIT;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != {CNT_W{1'b0}})) begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Handshake outputs, registered from the next state.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            r_req_ready  <= (w_next_state == ST_IDLE);
            r_resp_valid <= (w_next_state == ST_RESP);
        end
    end

    // Response data: cleared on acceptance, halves filled in CAPTURE.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_resp_data <= 32'h0000_0000;
        end else if (w_accept) begin
            r_resp_data <= 32'h0000_0000;
        end else if (r_state == ST_CAPTURE) begin
            if (r_beat) begin
                r_resp_data[31:16] <= data_out_io;
            end else begin
                r_resp_data[15:0]  <= data_out_io;
            end
        end else begin
            r_resp_data <= r_resp_data;
        end
    end

    // IO port drive: one cycle per beat; address holds between beats so the
    // IO read mux stays stable while the load latency elapses.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_address_io <= 32'h0000_0000;
            r_control_io <= 2'b00;
            r_data_in_io <= 16'h0000;
        end else if (w_next_state == ST_DRIVE) begin
            r_address_io <= w_drive_addr;
            r_control_io <= w_drive_ctrl;
            r_data_in_io <= w_drive_data;
        end else begin
            r_address_io <= r_address_io;
            r_control_io <= 2'b00;
            r_data_in_io <= 16'h0000;
        end
    end

endmodule

// File: doc/io_bus_sequencer.md
# io_bus_sequencer

Request sequencer between the CPU load/store path and the `memory_io` IO port. It accepts one byte, word or dword request at a time over a valid/ready handshake and drives `address_io`/`control_io`/`data_in_io` for exactly one cycle per 16-bit beat. It waits out the IO block's fixed 2-cycle read latency, splits dword accesses into two word beats and returns one response pulse per request.

## Interface
Parameters:
- `READ_LATENCY`, 2, cycles from the beat-drive cycle to the cycle in which `data_out_io` is valid for that beat.

Ports (one clock; reset is synchronous and active-high):
- `main_clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = word, 2 = dword, 3 = reserved (treated as word).
- `req_address`  in  32  byte address; bit 31 must be set for IO space (not checked).
- `req_data`  in  32  store data; byte uses [7:0], word uses [15:0].
- `resp_valid`  out  1  one-cycle completion pulse; there is no backpressure.
- `resp_data`  out  32  load result, zero-extended; 0 for stores.
- `address_io`  out  32  to `memory_io`.
- `control_io`  out  2  {partial_write, byte_op} to `memory_io`.
- `data_in_io`  out  16  to `memory_io`.
- `data_out_io`  in  16  from `memory_io`.

## Operation
- States: IDLE, DRIVE, WAIT, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch write, size, address and data; go to DRIVE with beat=0.
- DRIVE, one cycle, presents the beat:
  - `address_io`: byte = `req_address`; word/dword = `{addr[31:1],1'b0}`; beat 1 = beat-0 address + 2, with 32-bit wrap.
  - `control_io[0]` = (size==byte).
  - `control_io[1]` = write.
  - `data_in_io`: byte = `{8'h0,data[7:0]}`; word/dword beat 0 = `data[15:0]`; beat 1 = `data[31:16]`.
- After DRIVE:
  - Store: go to DRIVE for beat 1 (dword beat 0 only), else RESP.
  - Load: go to WAIT.
- WAIT: lasts `READ_LATENCY`-1 cycles, counted by a down-counter; then CAPTURE.
- CAPTURE:
  - Store `data_out_io` into `resp_data[15:0]` (beat 0) or `[31:16]` (beat 1).
  - Dword beat 0 goes to DRIVE for beat 1; otherwise RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE. `resp_data` holds until the next request is accepted.
- Outside DRIVE:
  - `control_io`=2'b00 and `data_in_io`=0.
  - `address_io` holds the last driven value, so the IO read mux stays stable.
- Byte loads: `memory_io` already returns `{8'h0,byte}`; the sequencer zero-extends to 32 bits.
- Dword store beats are non-atomic: two separate one-cycle writes.

## Timing
- Reset values:
  - State IDLE, `req_ready`=1, `resp_valid`=0.
  - `resp_data`=0, `address_io`=0, `control_io`=0, `data_in_io`=0.
- Accept at edge E (valid&&ready). DRIVE is cycle E+1.
- Load (word/byte): CAPTURE at cycle E+1+`READ_LATENCY`; `resp_valid` one cycle later. With the default this is a 4-cycle acceptance-to-response latency.
- Dword load: 7 cycles. Store: 2 cycles. Dword store: 3 cycles.
- Back-to-back: the next request is accepted in the cycle after RESP (IDLE). Maximum rate is one request per latency+1.
- `control_io[1]` is high for exactly one cycle per store beat, never for loads.
- Reset mid-operation:
  - Next state is IDLE, with no `resp_valid`.
  - `control_io` is 0 from the cycle after reset is sampled.
  - A beat already driven is not retracted.
- `req_valid` while not ready is ignored; the requester holds it.

## Structure
- Package `io_seq_pkg` holds:
  - the state enum;
  - size encodings `SZ_BYTE`, `SZ_WORD`, `SZ_DWORD`;
  - `CTRL_BYTE`/`CTRL_WRITE` bit indices.
- No sub-module is needed: a single FSM plus latency counter and beat flag.

## Test plan
- Word load at 0x8080_0010, with `data_out_io`=0xBEEF two cycles after DRIVE -> `address_io`=0x8080_0010, `control_io`=00, `resp_valid` 4 cycles after accept, `resp_data`=0x0000_BEEF.
- Byte store 0xA5 at 0x8000_0003 -> a single DRIVE cycle with `control_io`=11 and `data_in_io`=0x00A5; RESP next cycle.
- Dword load at 0x8100_0004, model returns 0x1111 then 0x2222 -> beats at 0x8100_0004 and 0x8100_0006; `resp_data`=0x2222_1111, 7 cycles.
- Dword store 0xCAFE_F00D at 0xFFFF_FFFE -> beat 0 at 0xFFFF_FFFE with 0xF00D; beat 1 wraps to 0x0000_0000 with 0xCAFE.
- Reset asserted in WAIT of a load -> no `resp_valid`, `req_ready`=1 next cycle, `control_io`=00.
- Odd word address 0x8000_0005 -> driven as 0x8000_0004 with `control_io[0]`=0.
